// File: rtl/rob_ring.sv
// Parametrised reorder buffer: in-order allocate/retire, NUM_WB writeback ports, branch resolve and flush.
// Optional macro ROB_BYPASS_EN forwards same-cycle accepted writebacks onto the lookup ports.
module rob_ring #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int NUM_WB = 2,
  parameter int BHT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  output logic [TAG_W-1:0]        alloc_tag,
  input  logic [2:0]              alloc_type,
  input  logic [31:0]             alloc_pc,
  input  logic [31:0]             alloc_inst,
  input  logic [31:0]             alloc_target,
  input  logic [4:0]              alloc_dest,
  input  logic                    alloc_pred,
  input  logic                    alloc_done,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*TAG_W-1:0] wb_tag,
  input  logic [NUM_WB*32-1:0]    wb_value,
  input  logic [NUM_WB*32-1:0]    wb_target,
  input  logic [TAG_W-1:0]        q_tag0,
  input  logic [TAG_W-1:0]        q_tag1,
  output logic                    q_ready0,
  output logic                    q_ready1,
  output logic [31:0]             q_value0,
  output logic [31:0]             q_value1,
  output logic                    commit_valid,
  output logic [TAG_W-1:0]        commit_tag,
  output logic                    commit_reg_we,
  output logic [4:0]              commit_dest,
  output logic [31:0]             commit_value,
  output logic                    head_mem_go,
  output logic                    bht_upd,
  output logic                    bht_taken,
  output logic [BHT_W-1:0]        bht_idx,
  output logic                    flush,
  output logic [31:0]             redirect_pc,
  output logic                    empty
);

  localparam logic [2:0] T_ALU    = 3'd0;
  localparam logic [2:0] T_LOAD   = 3'd1;
  localparam logic [2:0] T_STORE  = 3'd2;
  localparam logic [2:0] T_BRANCH = 3'd3;
  localparam logic [2:0] T_JAL    = 3'd4;
  localparam logic [2:0] T_JALR   = 3'd5;

  localparam logic [TAG_W:0]   CNT_ZERO = {(TAG_W+1){1'b0}};
  localparam logic [TAG_W:0]   CNT_ONE  = {{TAG_W{1'b0}}, 1'b1};
  localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] TAG_ZERO = {TAG_W{1'b0}};
  localparam logic [TAG_W-1:0] TAG_ONE  = {{(TAG_W-1){1'b0}}, 1'b1};

  logic [TAG_W-1:0] head_r, tail_r;
  logic [TAG_W:0]   count_r;
  logic [DEPTH-1:0] valid_r, ready_r, pred_r;
  logic [2:0]       type_r   [DEPTH];
  logic [31:0]      pc_r     [DEPTH];
  logic [BHT_W-1:0] bidx_r   [DEPTH];
  logic [4:0]       dest_r   [DEPTH];
  logic [31:0]      target_r [DEPTH];
  logic [31:0]      value_r  [DEPTH];

  logic              alloc_ready_s, alloc_fire_s, head_ready_s, commit_s;
  logic              reg_we_s, bht_upd_s, flush_s;
  logic [31:0]       redirect_s, head_val_s;
  logic [2:0]        head_type_s;
  logic [NUM_WB-1:0] wb_acc_s;
  logic              unused_s;

  // only the BHT index field of the instruction is retained per entry
  assign unused_s = ^{alloc_inst[31:BHT_W+2], alloc_inst[1:0]};

  assign alloc_ready_s = (count_r != CNT_FULL);
  assign alloc_ready   = alloc_ready_s;
  assign alloc_tag     = tail_r;
  assign empty         = (count_r == CNT_ZERO);
  assign head_type_s   = type_r[head_r];
  assign head_val_s    = value_r[head_r];
  assign head_ready_s  = (count_r != CNT_ZERO) && ready_r[head_r];
  assign commit_s      = rdy && head_ready_s;
  assign alloc_fire_s  = alloc_valid && alloc_ready_s && rdy && !flush_s;

  assign commit_valid  = commit_s;
  assign commit_tag    = head_r;
  assign commit_reg_we = reg_we_s;
  assign commit_dest   = dest_r[head_r];
  assign commit_value  = head_val_s;
  assign bht_upd       = bht_upd_s;
  assign bht_taken     = bht_upd_s && head_val_s[0];
  assign bht_idx       = bidx_r[head_r];
  assign flush         = flush_s;
  assign redirect_pc   = redirect_s;
  assign head_mem_go   = rdy && (count_r != CNT_ZERO) && !ready_r[head_r] &&
                         ((head_type_s == T_LOAD) || (head_type_s == T_STORE));

  // retirement decode: register write, branch resolution and redirect
  always_comb begin
    reg_we_s   = 1'b0;
    bht_upd_s  = 1'b0;
    flush_s    = 1'b0;
    redirect_s = 32'd0;
    if (commit_s) begin
      case (head_type_s)
        T_ALU, T_LOAD, T_JAL: reg_we_s = 1'b1;
        T_STORE:              reg_we_s = 1'b0;
        T_BRANCH: begin
          bht_upd_s = 1'b1;
          if (head_val_s[0] != pred_r[head_r]) begin
            flush_s    = 1'b1;
            redirect_s = head_val_s[0] ? target_r[head_r] : (pc_r[head_r] + 32'd4);
          end else begin
            flush_s = 1'b0;
          end
        end
        T_JALR: begin
          reg_we_s   = 1'b1;
          flush_s    = 1'b1;
          redirect_s = target_r[head_r];
        end
        default: reg_we_s = 1'b0;
      endcase
    end else begin
      reg_we_s = 1'b0;
    end
  end

  // a writeback lands only on a live entry and is dropped by a stall or a flush
  always_comb begin
    wb_acc_s = {NUM_WB{1'b0}};
    for (int p = 0; p < NUM_WB; p++) begin
      wb_acc_s[p] = wb_valid[p] && valid_r[wb_tag[p*TAG_W +: TAG_W]] && rdy && !flush_s;
    end
  end

  // operand lookup ports, optionally forwarding same-cycle writebacks
  always_comb begin
    q_ready0 = ready_r[q_tag0];
    q_value0 = value_r[q_tag0];
    q_ready1 = ready_r[q_tag1];
    q_value1 = value_r[q_tag1];
`ifdef ROB_BYPASS_EN
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_acc_s[p] && (wb_tag[p*TAG_W +: TAG_W] == q_tag0)) begin
        q_ready0 = 1'b1;
        q_value0 = wb_value[p*32 +: 32];
      end else begin
        q_ready0 = q_ready0;
      end
      if (wb_acc_s[p] && (wb_tag[p*TAG_W +: TAG_W] == q_tag1)) begin
        q_ready1 = 1'b1;
        q_value1 = wb_value[p*32 +: 32];
      end else begin
        q_ready1 = q_ready1;
      end
    end
`else
    q_ready0 = q_ready0;
`endif
  end

  // entry array, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= TAG_ZERO;
      tail_r  <= TAG_ZERO;
      count_r <= CNT_ZERO;
      valid_r <= {DEPTH{1'b0}};
      ready_r <= {DEPTH{1'b0}};
      pred_r  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        type_r[i]   <= 3'd0;
        pc_r[i]     <= 32'd0;
        bidx_r[i]   <= {BHT_W{1'b0}};
        dest_r[i]   <= 5'd0;
        target_r[i] <= 32'd0;
        value_r[i]  <= 32'd0;
      end
    end else if (rdy) begin
      if (flush_s) begin
        head_r  <= TAG_ZERO;
        tail_r  <= TAG_ZERO;
        count_r <= CNT_ZERO;
        valid_r <= {DEPTH{1'b0}};
        ready_r <= {DEPTH{1'b0}};
      end else begin
        // later ports overwrite earlier ones on a shared tag
        for (int p = 0; p < NUM_WB; p++) begin
          if (wb_acc_s[p]) begin
            ready_r[wb_tag[p*TAG_W +: TAG_W]]  <= 1'b1;
            value_r[wb_tag[p*TAG_W +: TAG_W]]  <= wb_value[p*32 +: 32];
            target_r[wb_tag[p*TAG_W +: TAG_W]] <= wb_target[p*32 +: 32];
          end
        end
        if (commit_s) begin
          valid_r[head_r] <= 1'b0;
          head_r          <= head_r + TAG_ONE;
        end
        if (alloc_fire_s) begin
          valid_r[tail_r]  <= 1'b1;
          ready_r[tail_r]  <= alloc_done;
          pred_r[tail_r]   <= alloc_pred;
          type_r[tail_r]   <= alloc_type;
          pc_r[tail_r]     <= alloc_pc;
          bidx_r[tail_r]   <= alloc_inst[BHT_W+1:2];
          dest_r[tail_r]   <= alloc_dest;
          target_r[tail_r] <= alloc_target;
          value_r[tail_r]  <= 32'd0;
          tail_r           <= tail_r + TAG_ONE;
        end
        count_r <= count_r + (alloc_fire_s ? CNT_ONE : CNT_ZERO) - (commit_s ? CNT_ONE : CNT_ZERO);
      end
    end
  end

endmodule

// File: tb/tb_rob_ring.sv
// Directed self-checking bench for rob_ring (default parameters).
module tb_rob_ring;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        alloc_valid, alloc_ready;
  logic [3:0]  alloc_tag;
  logic [2:0]  alloc_type;
  logic [31:0] alloc_pc, alloc_inst, alloc_target;
  logic [4:0]  alloc_dest;
  logic        alloc_pred, alloc_done;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_tag;
  logic [63:0] wb_value, wb_target;
  logic [3:0]  q_tag0, q_tag1;
  logic        q_ready0, q_ready1;
  logic [31:0] q_value0, q_value1;
  logic        commit_valid, commit_reg_we;
  logic [3:0]  commit_tag;
  logic [4:0]  commit_dest;
  logic [31:0] commit_value;
  logic        head_mem_go, bht_upd, bht_taken, flush, empty;
  logic [7:0]  bht_idx;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_head, exp_tail;
  logic [4:0] dq[$];
  logic [4:0] dexp;

`ifdef ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  rob_ring dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_type(alloc_type), .alloc_pc(alloc_pc), .alloc_inst(alloc_inst),
    .alloc_target(alloc_target), .alloc_dest(alloc_dest), .alloc_pred(alloc_pred),
    .alloc_done(alloc_done), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .wb_target(wb_target), .q_tag0(q_tag0), .q_tag1(q_tag1), .q_ready0(q_ready0),
    .q_ready1(q_ready1), .q_value0(q_value0), .q_value1(q_value1),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_reg_we(commit_reg_we),
    .commit_dest(commit_dest), .commit_value(commit_value), .head_mem_go(head_mem_go),
    .bht_upd(bht_upd), .bht_taken(bht_taken), .bht_idx(bht_idx), .flush(flush),
    .redirect_pc(redirect_pc), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic clr;
    alloc_valid = 1'b0; alloc_type = 3'd0; alloc_pc = 32'd0; alloc_inst = 32'd0;
    alloc_target = 32'd0; alloc_dest = 5'd0; alloc_pred = 1'b0; alloc_done = 1'b0;
    wb_valid = 2'b00; wb_tag = 8'd0; wb_value = 64'd0; wb_target = 64'd0;
  endtask

  task automatic alloc(input logic [2:0] t, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] tgt, input logic [4:0] d, input logic pr, input logic dn);
    alloc_valid = 1'b1; alloc_type = t; alloc_pc = pc; alloc_inst = inst;
    alloc_target = tgt; alloc_dest = d; alloc_pred = pr; alloc_done = dn;
  endtask

  task automatic wb(input int p, input logic [3:0] tg, input logic [31:0] v, input logic [31:0] tgt);
    wb_valid[p] = 1'b1;
    wb_tag[p*4 +: 4] = tg;
    wb_value[p*32 +: 32] = v;
    wb_target[p*32 +: 32] = tgt;
  endtask

  task automatic do_reset;
    clr;
    rdy = 1'b1; q_tag0 = 4'd0; q_tag1 = 4'd0;
    rst = 1'b1;
    step;
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset;
    settle;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_mem_go", head_mem_go, 0);
    chk("rst_q_ready0", q_ready0, 0);
    chk("rst_q_value0", q_value0, 0);
    chk("rst_alloc_tag", alloc_tag, 0);

    // fill all 16 entries, then a 17th request is refused
    for (int i = 0; i < 16; i++) begin
      clr; alloc(3'd0, 32'h1000, 32'd0, 32'd0, 5'(i), 1'b0, 1'b0);
      settle;
      chk("fill_tag", alloc_tag, i);
      chk("fill_ready", alloc_ready, 1);
      step;
    end
    clr; alloc(3'd0, 32'h1000, 32'd0, 32'd0, 5'd31, 1'b0, 1'b0);
    settle;
    chk("full_ready", alloc_ready, 0);
    chk("full_empty", empty, 0);
    step;
    clr; settle;
    chk("full_tag_held", alloc_tag, 0);
    chk("full_still", alloc_ready, 0);

    // lookup after writeback of tag 3
    clr; wb(0, 4'd3, 32'h77, 32'd0); q_tag0 = 4'd3;
    settle;
    chk("byp_ready", q_ready0, BYP ? 1 : 0);
    chk("byp_value", q_value0, BYP ? 32'h77 : 32'h0);
    step;
    clr; settle;
    chk("look_ready", q_ready0, 1);
    chk("look_value", q_value0, 32'h77);

    // single ALU commit
    do_reset;
    clr; alloc(3'd0, 32'h40, 32'd0, 32'd0, 5'd5, 1'b0, 1'b0); step;
    clr; wb(0, 4'd0, 32'h1234, 32'd0); settle;
    chk("alu_not_yet", commit_valid, 0);
    step;
    clr; settle;
    chk("alu_cv", commit_valid, 1);
    chk("alu_we", commit_reg_we, 1);
    chk("alu_dest", commit_dest, 5);
    chk("alu_value", commit_value, 32'h1234);
    chk("alu_tag", commit_tag, 0);
    step;
    settle;
    chk("alu_empty", empty, 1);
    chk("alu_cv_after", commit_valid, 0);

    // ignored writebacks: invalid tag and same-cycle allocation; then port 1 wins
    clr; alloc(3'd0, 32'h44, 32'd0, 32'd0, 5'd7, 1'b0, 1'b0);
    wb(0, 4'd5, 32'h55, 32'd0); wb(1, 4'd1, 32'h99, 32'd0);
    q_tag0 = 4'd1; q_tag1 = 4'd5;
    step;
    clr; settle;
    chk("wb_inval_ign", q_ready1, 0);
    chk("wb_alloc_ign", q_ready0, 0);
    chk("wb_alloc_cv", commit_valid, 0);
    wb(0, 4'd1, 32'hAAAA, 32'd0); wb(1, 4'd1, 32'hBBBB, 32'd0);
    step;
    clr; settle;
    chk("prio_cv", commit_valid, 1);
    chk("prio_tag", commit_tag, 1);
    chk("prio_value", commit_value, 32'hBBBB);
    step;

    // mispredicted taken branch, with an allocation in the flush cycle
    do_reset;
    clr; alloc(3'd3, 32'h100, 32'h154, 32'h180, 5'd0, 1'b0, 1'b0); step;
    clr; wb(0, 4'd0, 32'h1, 32'h200); step;
    clr; alloc(3'd0, 32'h104, 32'd0, 32'd0, 5'd9, 1'b0, 1'b1); settle;
    chk("br_flush", flush, 1);
    chk("br_redirect", redirect_pc, 32'h200);
    chk("br_upd", bht_upd, 1);
    chk("br_taken", bht_taken, 1);
    chk("br_idx", bht_idx, 8'h55);
    chk("br_we", commit_reg_we, 0);
    step;
    clr; settle;
    chk("br_post_empty", empty, 1);
    chk("br_post_tag", alloc_tag, 0);
    chk("br_post_flush", flush, 0);

    // mispredicted not-taken branch, held by rdy=0 for one cycle
    clr; alloc(3'd3, 32'h300, 32'd0, 32'h380, 5'd0, 1'b1, 1'b0); step;
    clr; wb(0, 4'd0, 32'h0, 32'h999); step;
    clr; rdy = 1'b0; q_tag0 = 4'd0; settle;
    chk("stall_cv", commit_valid, 0);
    chk("stall_flush", flush, 0);
    chk("stall_upd", bht_upd, 0);
    chk("stall_q_live", q_ready0, 1);
    step;
    rdy = 1'b1; settle;
    chk("nt_flush", flush, 1);
    chk("nt_redirect", redirect_pc, 32'h304);
    chk("nt_taken", bht_taken, 0);
    step;

    // JALR always redirects and writes its link value
    clr; alloc(3'd5, 32'h500, 32'd0, 32'd0, 5'd1, 1'b0, 1'b0); step;
    clr; wb(1, 4'd0, 32'h504, 32'h800); step;
    clr; settle;
    chk("jalr_flush", flush, 1);
    chk("jalr_redirect", redirect_pc, 32'h800);
    chk("jalr_we", commit_reg_we, 1);
    chk("jalr_value", commit_value, 32'h504);
    step;

    // store waiting at the head
    do_reset;
    clr; alloc(3'd2, 32'h600, 32'd0, 32'd0, 5'd3, 1'b0, 1'b0); step;
    clr; settle;
    chk("st_mem_go", head_mem_go, 1);
    wb(1, 4'd0, 32'h0, 32'd0); step;
    clr; settle;
    chk("st_cv", commit_valid, 1);
    chk("st_we", commit_reg_we, 0);
    chk("st_mem_go_off", head_mem_go, 0);
    step;

    // steady state: retire and allocate one per cycle across several wraps
    do_reset;
    dq.delete();
    for (int i = 0; i < 4; i++) begin
      clr; alloc(3'd0, 32'h0, 32'd0, 32'd0, 5'(i), 1'b0, 1'b0); step;
      dq.push_back(5'(i));
    end
    clr; wb(0, 4'd0, 32'h10, 32'd0); wb(1, 4'd1, 32'h11, 32'd0); step;
    exp_head = 4'd0; exp_tail = 4'd4;
    for (int k = 0; k < 40; k++) begin
      clr; alloc(3'd0, 32'h0, 32'd0, 32'd0, 5'(k + 4), 1'b0, 1'b1);
      if (k == 0) begin
        wb(0, 4'd2, 32'h12, 32'd0); wb(1, 4'd3, 32'h13, 32'd0);
      end
      settle;
      dexp = dq.pop_front();
      chk("wrap_cv", commit_valid, 1);
      chk("wrap_ctag", commit_tag, exp_head);
      chk("wrap_dest", commit_dest, dexp);
      chk("wrap_atag", alloc_tag, exp_tail);
      chk("wrap_ready", alloc_ready, 1);
      dq.push_back(5'(k + 4));
      exp_head = exp_head + 4'd1;
      exp_tail = exp_tail + 4'd1;
      step;
    end
    for (int k = 0; k < 4; k++) begin
      clr; settle;
      dexp = dq.pop_front();
      chk("drain_cv", commit_valid, 1);
      chk("drain_tag", commit_tag, exp_head);
      chk("drain_dest", commit_dest, dexp);
      exp_head = exp_head + 4'd1;
      step;
    end
    settle;
    chk("drain_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rob_ring.md
Name: rob_ring

Overview:
- Parametrised reorder buffer, the successor to the fixed-size single-writeback ROB in the out-of-order core.
- Allocates entries in program order from the instruction queue and accepts results from NUM_WB writeback ports (RS and SLB by default).
- Retires one instruction per cycle from the head, resolves branches against their prediction, and raises a self-contained flush with a redirect PC.
- Adds over the previous generation: explicit full/empty backpressure, per-entry valid bits, multi-port writeback, and operand lookup ports.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 4.
- TAG_W, 4, tag width; must equal log2(DEPTH).
- NUM_WB, 2, number of writeback ports.
- BHT_W, 8, width of the BHT index taken from inst[BHT_W+1:2].

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable; 0 freezes all state.
- alloc_valid  in  1  instruction queue requests an entry.
- alloc_ready  out  1  count < DEPTH.
- alloc_tag  out  TAG_W  tail index granted.
- alloc_type  in  3  0=ALU 1=LOAD 2=STORE 3=BRANCH 4=JAL 5=JALR.
- alloc_pc / alloc_inst / alloc_target  in  32 each  PC, raw instruction, predicted target.
- alloc_dest  in  5  destination register.
- alloc_pred  in  1  predicted taken.
- alloc_done  in  1  entry is ready at allocation.
- wb_valid  in  NUM_WB  writeback strobes.
- wb_tag  in  NUM_WB*TAG_W  writeback tags.
- wb_value  in  NUM_WB*32  results; for BRANCH bit0 = actual taken.
- wb_target  in  NUM_WB*32  resolved target (BRANCH/JALR).
- q_tag0, q_tag1  in  TAG_W  operand lookup tags.
- q_ready0, q_ready1  out  1  entry result available.
- q_value0, q_value1  out  32  entry result.
- commit_valid  out  1  head retires this cycle.
- commit_tag  out  TAG_W  tag of the retiring entry.
- commit_reg_we  out  1  retiring entry writes the register file.
- commit_dest  out  5  destination register.
- commit_value  out  32  value written.
- head_mem_go  out  1  head is an unready LOAD/STORE; SLB may issue.
- bht_upd  out  1  branch retired.
- bht_taken  out  1  actual direction.
- bht_idx  out  BHT_W  inst[BHT_W+1:2].
- flush  out  1  misprediction.
- redirect_pc  out  32  correct fetch PC.
- empty  out  1  count == 0.

Behaviour:
- State: head, tail (TAG_W bits, wrap modulo DEPTH); count (TAG_W+1 bits); per entry valid, ready, type, pc, inst, dest, pred, target, value.
- Reset (rst=1 at posedge): head = tail = count = 0; all valid and ready cleared.
- After reset, every output is 0 except alloc_ready=1 and empty=1, and q_* reflects the cleared arrays (0).
- rdy=0: no state change. commit_valid, commit_reg_we, head_mem_go, bht_upd and flush are forced to 0. Lookup outputs remain live.
- Allocation: when alloc_valid && alloc_ready && rdy && !flush, at the edge write entry[tail], set valid=1 and ready=alloc_done, then tail+1.
- alloc_tag = tail, combinational.
- alloc_ready ignores a same-cycle commit: a full buffer refuses allocation even while retiring.
- Writeback: for each port with wb_valid and entry[tag].valid, set ready=1, value=wb_value, and target=wb_target.
  - A writeback to an invalid entry is ignored.
  - Two ports hitting the same tag: the higher port index wins.
  - A writeback to the entry being allocated in the same cycle is ignored; the entry was not valid.
- Commit (combinational, from head, when count>0 and entry[head].ready):
  - ALU/LOAD/JAL: commit_reg_we=1.
  - STORE: commit_reg_we=0.
  - BRANCH: bht_upd=1. Mispredict = value[0] != pred. On mispredict, flush=1 and redirect_pc = value[0] ? target : pc+4.
  - JALR: always flush=1, redirect_pc=target, commit_reg_we=1.
- Retirement edge: head+1 and valid cleared, with count updated as count + alloc - commit.
- Commit and allocate in the same cycle leave count unchanged.
- head_mem_go = count>0, head type LOAD or STORE, and head not ready.
- Flush edge: the retiring entry's register write still occurs (commit_reg_we stays 1). At the edge head = tail = count = 0 and all valid/ready are cleared. Same-cycle allocation and writebacks are discarded.
- Wrap: tail and head roll from DEPTH-1 to 0. Full is count==DEPTH; empty is count==0.
- Lookup: q_readyN = entry[q_tagN].ready, q_valueN = entry[q_tagN].value, both combinational.

Optional Feature:
- ROB_BYPASS_EN
  - Defined: a lookup whose tag matches a same-cycle accepted writeback returns q_ready=1 and that port's wb_value (highest matching port wins).
  - Undefined: lookups see only registered state, so the result appears the cycle after writeback.

Test Plan:
- Reset, then allocate 16 ALU entries with no writeback: alloc_tag 0..15, alloc_ready=0 after the 16th, empty=0; a 17th alloc_valid is refused.
- Allocate ALU tag0 with dest=5; wb port0 tag0 value=0x1234 -> next cycle commit_valid=1, commit_reg_we=1, commit_dest=5, commit_value=0x1234; the following cycle empty=1.
- BRANCH at pc=0x100 with pred=0, writeback value=1 and target=0x200 -> flush=1, redirect_pc=0x200, bht_upd=1, bht_taken=1; next cycle count=0, and an allocation made in the flush cycle is absent.
- STORE at head, unready -> head_mem_go=1; writeback on port1 -> commits with commit_reg_we=0.
- Fill, then retire and allocate 40 entries one per cycle -> tags wrap 15 to 0, count stays constant, commit order is preserved.
- Writeback tag3 value 0x77 while q_tag0=3 -> q_ready0=1, q_value0=0x77 the same cycle with ROB_BYPASS_EN defined; one cycle later without it.
